// File: rtl/bcrypt_cmp_config_ctrl.sv
// Applies a new comparator/salt config to the bcrypt core array:
// drain in-flight jobs, copy the word store into the cores, then release.
module bcrypt_cmp_config_ctrl #(
    parameter int N_CORES   = 4,
    parameter int OUTST_W   = 8,
    parameter int CFG_WORDS = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               new_cmp_config,
    output logic               cmp_config_applied,
    output logic [3:0]         cfg_addr,
    input  logic [31:0]        cfg_dout,
    input  logic               job_start,
    input  logic               job_done,
    input  logic [N_CORES-1:0] core_idle,
    output logic               issue_en,
    output logic               core_cfg_wr_en,
    output logic [2:0]         core_cfg_addr,
    output logic [31:0]        core_cfg_data,
    output logic               busy,
    output logic               error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_COPY,
        S_APPLY,
        S_HOLD
    } state_t;

    localparam logic [OUTST_W-1:0] OUTST_MAX = '1;
    localparam logic [3:0]         LAST_IDX  = 4'(CFG_WORDS - 1);

    state_t             state;
    logic [OUTST_W-1:0] outstanding;
    logic               configured;
    logic [3:0]         word_idx;
    logic               inc;
    logic               dec;
    logic               drained;

    assign inc      = job_start & ~job_done;
    assign dec      = job_done & ~job_start;
    assign drained  = (outstanding == '0) & (&core_idle);

    assign issue_en = (state == S_IDLE) & configured;
    assign busy     = (state != S_IDLE);
    assign cfg_addr = (state == S_COPY) ? word_idx : 4'd0;

    // Job accounting runs in every state; faults never disturb the FSM.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            outstanding <= '0;
            error       <= 1'b0;
        end else begin
            if (inc && outstanding != OUTST_MAX)
                outstanding <= outstanding + 1'b1;
            else if (dec && outstanding != '0)
                outstanding <= outstanding - 1'b1;

            if ((inc && outstanding == OUTST_MAX) ||
                (dec && outstanding == '0) ||
                (job_start && !issue_en))
                error <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state              <= S_IDLE;
            configured         <= 1'b0;
            word_idx           <= 4'd0;
            core_cfg_wr_en     <= 1'b0;
            core_cfg_addr      <= 3'd0;
            core_cfg_data      <= 32'd0;
            cmp_config_applied <= 1'b0;
        end else begin
            core_cfg_wr_en     <= 1'b0;
            cmp_config_applied <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (new_cmp_config)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (drained) begin
                        state    <= S_COPY;
                        word_idx <= 4'd0;
                    end
                end
                S_COPY: begin
                    core_cfg_wr_en <= 1'b1;
                    core_cfg_addr  <= word_idx[2:0];
                    core_cfg_data  <= cfg_dout;
                    word_idx       <= word_idx + 1'b1;
                    // Pulse lands together with the final strobe.
                    if (word_idx == LAST_IDX) begin
                        state              <= S_APPLY;
                        cmp_config_applied <= 1'b1;
                        configured         <= 1'b1;
                    end
                end
                S_APPLY: begin
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    if (!new_cmp_config)
                        state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcrypt_cmp_config_ctrl.sv
// Directed-plus-random bench for bcrypt_cmp_config_ctrl with a
// job-accounting reference model and event-time expectations.
module tb_bcrypt_cmp_config_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        new_cmp_config = 1'b0;
    logic        job_start = 1'b0;
    logic        job_done = 1'b0;
    logic [3:0]  core_idle = 4'hF;
    logic [31:0] cfg_dout;
    logic        cmp_config_applied;
    logic [3:0]  cfg_addr;
    logic        issue_en;
    logic        core_cfg_wr_en;
    logic [2:0]  core_cfg_addr;
    logic [31:0] core_cfg_data;
    logic        busy;
    logic        error;

    logic [31:0] store [16];
    int          pass_n = 0;
    int          fail_n = 0;
    int          total_n = 0;
    int          m_out = 0;
    bit          m_err = 1'b0;
    bit          m_issue = 1'b0;

    always #5 CLK = ~CLK;
    always_comb cfg_dout = store[cfg_addr];

    bcrypt_cmp_config_ctrl #(
        .N_CORES(4),
        .OUTST_W(8),
        .CFG_WORDS(5)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .new_cmp_config(new_cmp_config),
        .cmp_config_applied(cmp_config_applied),
        .cfg_addr(cfg_addr),
        .cfg_dout(cfg_dout),
        .job_start(job_start),
        .job_done(job_done),
        .core_idle(core_idle),
        .issue_en(issue_en),
        .core_cfg_wr_en(core_cfg_wr_en),
        .core_cfg_addr(core_cfg_addr),
        .core_cfg_data(core_cfg_data),
        .busy(busy),
        .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: fold this cycle's inputs into the model first.
    task automatic tick();
        if (RESET) begin
            m_out = 0;
            m_err = 1'b0;
        end else begin
            if (job_start && !m_issue)
                m_err = 1'b1;
            if (job_start && !job_done) begin
                if (m_out == 255) m_err = 1'b1;
                else m_out++;
            end else if (job_done && !job_start) begin
                if (m_out == 0) m_err = 1'b1;
                else m_out--;
            end
        end
        @(posedge CLK);
        #1;
        chk("error", error, 32'(m_err));
    endtask

    task automatic randomize_store();
        for (int k = 0; k < 16; k++)
            store[k] = $urandom;
    endtask

    // Called in the cycle where the drain condition is true.
    task automatic expect_copy();
        tick();
        chk("copy0_addr", cfg_addr, 0);
        chk("copy0_wr", core_cfg_wr_en, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("strobe_wr", core_cfg_wr_en, 1);
            chk("strobe_addr", core_cfg_addr, k);
            chk("strobe_data", core_cfg_data, store[k]);
            chk("strobe_applied", cmp_config_applied, (k == 4) ? 1 : 0);
            chk("cfg_addr", cfg_addr, (k < 4) ? k + 1 : 0);
            chk("copy_issue", issue_en, 0);
        end
        tick();
        chk("hold_wr", core_cfg_wr_en, 0);
        chk("hold_applied", cmp_config_applied, 0);
        chk("hold_busy", busy, 1);
    endtask

    task automatic start_request();
        new_cmp_config = 1'b1;
        chk("issue_pre", issue_en, 32'(m_issue));
        tick();
        m_issue = 1'b0;
        chk("issue_drop", issue_en, 0);
        chk("busy_drain", busy, 1);
    endtask

    task automatic finish_hold(input int extra);
        for (int n = 0; n < extra; n++) begin
            tick();
            chk("hold_busy_x", busy, 1);
            chk("hold_applied_x", cmp_config_applied, 0);
            chk("hold_issue_x", issue_en, 0);
        end
        new_cmp_config = 1'b0;
        tick();
        m_issue = 1'b1;
        chk("idle_busy", busy, 0);
        chk("idle_issue", issue_en, 1);
    endtask

    task automatic pulse_start();
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
    endtask

    initial begin
        bit done_f;
        randomize_store();
        store[0] = 32'h5;
        store[1] = 32'hA1;
        store[2] = 32'hA2;
        store[3] = 32'hA3;
        store[4] = 32'hA4;

        // Reset state
        RESET = 1'b1;
        tick();
        tick();
        chk("rst_applied", cmp_config_applied, 0);
        chk("rst_cfg_addr", cfg_addr, 0);
        chk("rst_issue", issue_en, 0);
        chk("rst_wr", core_cfg_wr_en, 0);
        chk("rst_core_addr", core_cfg_addr, 0);
        chk("rst_core_data", core_cfg_data, 0);
        chk("rst_busy", busy, 0);
        RESET = 1'b0;
        tick();

        // Fixed store, nothing in flight: 7-cycle latency
        start_request();
        expect_copy();
        finish_hold(0);

        // Two jobs, a simultaneous start/done, one more job
        randomize_store();
        pulse_start();
        pulse_start();
        job_start = 1'b1;
        job_done = 1'b1;
        tick();
        job_start = 1'b0;
        job_done = 1'b0;
        chk("both_err", error, 0);
        pulse_start();

        // Drain three jobs with random done timing and idle flags
        start_request();
        done_f = 1'b0;
        for (int n = 0; n < 200 && !done_f; n++) begin
            job_done = (m_out > 0) && ($urandom_range(0, 2) == 0);
            core_idle = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            if (m_out == 0 && core_idle == 4'hF) begin
                expect_copy();
                done_f = 1'b1;
            end else begin
                tick();
                job_done = 1'b0;
                chk("drain_wr", core_cfg_wr_en, 0);
                chk("drain_busy", busy, 1);
                chk("drain_issue", issue_en, 0);
            end
        end
        chk("drain_finished", 32'(done_f), 1);
        job_done = 1'b0;
        core_idle = 4'hF;
        // Hold new_cmp_config four cycles past the pulse
        finish_hold(3);

        // Spurious job_done with nothing outstanding
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
        chk("underflow_err", error, 1);
        repeat (3) tick();
        chk("underflow_busy", busy, 0);
        chk("underflow_issue", issue_en, 1);

        // Reset on the third COPY cycle, then full replay
        randomize_store();
        start_request();
        tick();
        tick();
        tick();
        chk("mid_wr", core_cfg_wr_en, 1);
        chk("mid_addr", core_cfg_addr, 1);
        RESET = 1'b1;
        new_cmp_config = 1'b0;
        m_issue = 1'b0;
        tick();
        chk("rst_mid_wr", core_cfg_wr_en, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_issue", issue_en, 0);
        chk("rst_mid_applied", cmp_config_applied, 0);
        RESET = 1'b0;
        tick();
        tick();
        chk("unconfigured_issue", issue_en, 0);
        randomize_store();
        start_request();
        expect_copy();
        finish_hold($urandom_range(0, 2));

        // Job launched while issue is blocked
        RESET = 1'b1;
        m_issue = 1'b0;
        tick();
        RESET = 1'b0;
        tick();
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        chk("blocked_start_err", error, 1);
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
        randomize_store();
        start_request();
        expect_copy();
        finish_hold(1);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
